dma_cmd_issuer: RTL and testbench

DMA_CMD_ISSUER -- requirements
Module: dma_cmd_issuer

---
 rtl/dma_cmd_issuer.sv | 203 ++++++++++++++++++++
 tb/tb_dma_cmd_issuer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cmd_issuer.sv
// ---------------------------------------------------------------------------
// dma_cmd_issuer
//
// Queues transfer commands from a requester and issues them one at a time to
// a DMA frontend. It keeps a bounded number of transfers in flight and returns
// the requester tag of each transfer when the frontend reports completion.
// Completions arrive in issue order, so the tags wait in a simple in-order
// tag FIFO.
//
// Parameters
//   FifoDepth      : command FIFO entries (power of two, >= 2)
//   MaxOutstanding : maximum issued but uncompleted transfers (>= 1)
//   TagWidth       : width of the requester tag
//   transf_descr_t : transfer descriptor type (matches the DMA frontend port)
//
// Ports
//   clk_i           : clock, all logic on the rising edge
//   rst_ni          : asynchronous active-low reset
//   cmd_valid_i     : requester offers a command
//   cmd_ready_o     : command FIFO can accept (not full)
//   cmd_descr_i     : descriptor to issue
//   cmd_tag_i       : requester tag returned on completion
//   dma_req_valid_o : descriptor offered to the DMA frontend
//   dma_req_ready_i : frontend accepts the descriptor
//   dma_req_o       : descriptor to the frontend (head of the command FIFO)
//   dma_rsp_valid_i : one-cycle pulse per completed transfer, in issue order
//   cpl_valid_o     : one-cycle completion pulse to the requester
//   cpl_tag_o       : tag of the completed command, held between pulses
//   outstanding_o   : number of issued, uncompleted transfers
//   idle_o          : nothing queued and nothing in flight
//   spurious_rsp_o  : sticky, a response arrived with nothing in flight
// ---------------------------------------------------------------------------
module dma_cmd_issuer #(
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned TagWidth       = 8,
  parameter type         transf_descr_t = logic
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 cmd_valid_i,
  output logic                                 cmd_ready_o,
  input  transf_descr_t                        cmd_descr_i,
  input  logic [TagWidth-1:0]                  cmd_tag_i,
  output logic                                 dma_req_valid_o,
  input  logic                                 dma_req_ready_i,
  output transf_descr_t                        dma_req_o,
  input  logic                                 dma_rsp_valid_i,
  output logic                                 cpl_valid_o,
  output logic [TagWidth-1:0]                  cpl_tag_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 idle_o,
  output logic                                 spurious_rsp_o
);

  localparam int unsigned FifoPtrW = $clog2(FifoDepth);
  localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);
  localparam int unsigned TagPtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic [FifoPtrW:0]  CmdPtrOne = {{FifoPtrW{1'b0}}, 1'b1};
  localparam logic [CntW-1:0]    CntOne    = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0]    CntMax    = CntW'(MaxOutstanding);
  localparam logic [TagPtrW-1:0] TagPtrOne = {{(TagPtrW-1){1'b0}}, 1'b1};
  localparam logic [TagPtrW-1:0] TagPtrLast = TagPtrW'(MaxOutstanding - 1);

  // Command FIFO storage and pointers. The pointers carry one extra wrap bit
  // so that full and empty can be told apart when the index bits match.
  transf_descr_t         cmd_descr_mem [FifoDepth];
  logic [TagWidth-1:0]   cmd_tag_mem   [FifoDepth];
  logic [FifoPtrW:0]     cmd_wr_ptr_q;
  logic [FifoPtrW:0]     cmd_rd_ptr_q;
  logic                  cmd_empty;
  logic                  cmd_full;
  logic                  cmd_push;

  // In-order tag FIFO for transfers in flight. Its occupancy is exactly the
  // outstanding counter, so no separate fill level is kept.
  logic [TagWidth-1:0]   tag_mem [MaxOutstanding];
  logic [TagPtrW-1:0]    tag_wr_ptr_q;
  logic [TagPtrW-1:0]    tag_rd_ptr_q;

  logic [CntW-1:0]       out_cnt_q;
  logic                  issue;
  logic                  rsp_pop;
  logic                  rsp_spurious;

  logic                  cpl_valid_q;
  logic [TagWidth-1:0]   cpl_tag_q;
  logic                  spurious_q;

  // Tag FIFO depth need not be a power of two, so its pointers wrap by
  // comparison rather than by natural overflow.
  function automatic logic [TagPtrW-1:0] tag_ptr_next(input logic [TagPtrW-1:0] ptr);
    if (ptr == TagPtrLast) begin
      return '0;
    end
    return ptr + TagPtrOne;
  endfunction

  // Status and handshake decode. Everything here comes from registered state
  // plus the current-cycle handshake inputs; the offer to the frontend uses
  // only registered state, so a response never reaches dma_req_valid_o
  // combinationally and a freed slot shows up the following cycle.
  always_comb begin
    cmd_empty       = (cmd_wr_ptr_q == cmd_rd_ptr_q);
    cmd_full        = (cmd_wr_ptr_q[FifoPtrW] != cmd_rd_ptr_q[FifoPtrW]) &&
                      (cmd_wr_ptr_q[FifoPtrW-1:0] == cmd_rd_ptr_q[FifoPtrW-1:0]);
    cmd_ready_o     = !cmd_full;
    cmd_push        = cmd_valid_i && !cmd_full;
    dma_req_valid_o = !cmd_empty && (out_cnt_q < CntMax);
    dma_req_o       = cmd_descr_mem[cmd_rd_ptr_q[FifoPtrW-1:0]];
    issue           = dma_req_valid_o && dma_req_ready_i;
    rsp_pop         = dma_rsp_valid_i && (out_cnt_q != '0);
    rsp_spurious    = dma_rsp_valid_i && (out_cnt_q == '0);
  end

  // Command FIFO payload. Descriptor storage is deliberately left without a
  // reset; the head is only meaningful while dma_req_valid_o is high.
  always_ff @(posedge clk_i) begin
    if (cmd_push) begin
      cmd_descr_mem[cmd_wr_ptr_q[FifoPtrW-1:0]] <= cmd_descr_i;
      cmd_tag_mem[cmd_wr_ptr_q[FifoPtrW-1:0]]   <= cmd_tag_i;
    end
  end

  // Command FIFO pointers. A full FIFO refuses a command even if the head
  // leaves in the same cycle, which keeps cmd_ready_o free of any dependence
  // on the frontend handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
    end else begin
      if (cmd_push) begin
        cmd_wr_ptr_q <= cmd_wr_ptr_q + CmdPtrOne;
      end
      if (issue) begin
        cmd_rd_ptr_q <= cmd_rd_ptr_q + CmdPtrOne;
      end
    end
  end

  // Tag FIFO payload. An issue writes at the tail while a response reads the
  // head; with at least one transfer in flight and room for another these
  // are different slots, so a same-cycle pop always sees the oldest tag.
  always_ff @(posedge clk_i) begin
    if (issue) begin
      tag_mem[tag_wr_ptr_q] <= cmd_tag_mem[cmd_rd_ptr_q[FifoPtrW-1:0]];
    end
  end

  // Tag FIFO pointers and the outstanding counter. A simultaneous issue and
  // response leaves the count unchanged while both pointers advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      out_cnt_q    <= '0;
    end else begin
      if (issue) begin
        tag_wr_ptr_q <= tag_ptr_next(tag_wr_ptr_q);
      end
      if (rsp_pop) begin
        tag_rd_ptr_q <= tag_ptr_next(tag_rd_ptr_q);
      end
      case ({issue, rsp_pop})
        2'b10:   out_cnt_q <= out_cnt_q + CntOne;
        2'b01:   out_cnt_q <= out_cnt_q - CntOne;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  // Completion output, one cycle after the response. The tag register only
  // loads on a real completion so it keeps showing the last completed tag.
  // A response with nothing in flight raises the sticky spurious flag instead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cpl_valid_q <= 1'b0;
      cpl_tag_q   <= '0;
      spurious_q  <= 1'b0;
    end else begin
      cpl_valid_q <= rsp_pop;
      if (rsp_pop) begin
        cpl_tag_q <= tag_mem[tag_rd_ptr_q];
      end
      if (rsp_spurious) begin
        spurious_q <= 1'b1;
      end
    end
  end

  // Idle means nothing queued and nothing in flight; an empty tag FIFO is
  // implied by a zero count.
  always_comb begin
    cpl_valid_o    = cpl_valid_q;
    cpl_tag_o      = cpl_tag_q;
    outstanding_o  = out_cnt_q;
    spurious_rsp_o = spurious_q;
    idle_o         = cmd_empty && (out_cnt_q == '0);
  end

endmodule

// File: tb/tb_dma_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_dma_cmd_issuer
//
// Bench for dma_cmd_issuer with FifoDepth=4, MaxOutstanding=8, TagWidth=8 and
// a 32-bit descriptor. A queue-based reference model tracks queued commands,
// in-flight tags and the completion/spurious outputs; directed scenario tasks
// and a randomized run compare the design against it and against constants.
// ---------------------------------------------------------------------------
module tb_dma_cmd_issuer;

  localparam int FifoDepth = 4;
  localparam int MaxOut    = 8;
  localparam int TagW      = 8;

  typedef logic [31:0] descr_t;

  typedef struct {
    descr_t          d;
    logic [TagW-1:0] t;
  } cmd_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  descr_t          cmd_descr;
  logic [TagW-1:0] cmd_tag;
  logic            dma_req_valid;
  logic            dma_req_ready;
  descr_t          dma_req;
  logic            dma_rsp_valid;
  logic            cpl_valid;
  logic [TagW-1:0] cpl_tag;
  logic [3:0]      outstanding;
  logic            idle;
  logic            spurious;

  int errors = 0;
  int checks = 0;
  int dut_issues = 0;

  // Reference model state
  cmd_t            m_cmdq[$];
  logic [TagW-1:0] m_tagq[$];
  int              m_cnt = 0;
  bit              m_spur = 1'b0;
  bit              m_cpl_v = 1'b0;
  logic [TagW-1:0] m_cpl_tag = '0;

  always #5 clk = ~clk;

  dma_cmd_issuer #(
    .FifoDepth      (FifoDepth),
    .MaxOutstanding (MaxOut),
    .TagWidth       (TagW),
    .transf_descr_t (descr_t)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_descr_i     (cmd_descr),
    .cmd_tag_i       (cmd_tag),
    .dma_req_valid_o (dma_req_valid),
    .dma_req_ready_i (dma_req_ready),
    .dma_req_o       (dma_req),
    .dma_rsp_valid_i (dma_rsp_valid),
    .cpl_valid_o     (cpl_valid),
    .cpl_tag_o       (cpl_tag),
    .outstanding_o   (outstanding),
    .idle_o          (idle),
    .spurious_rsp_o  (spurious)
  );

  function automatic bit m_ready();
    return m_cmdq.size() < FifoDepth;
  endfunction

  function automatic bit m_req_valid();
    return (m_cmdq.size() > 0) && (m_cnt < MaxOut);
  endfunction

  function automatic bit m_idle();
    return (m_cmdq.size() == 0) && (m_cnt == 0);
  endfunction

  // Model reaction to reset: everything queued or in flight is forgotten.
  task automatic model_reset();
    m_cmdq.delete();
    m_tagq.delete();
    m_cnt     = 0;
    m_spur    = 1'b0;
    m_cpl_v   = 1'b0;
    m_cpl_tag = '0;
  endtask

  // Model reaction to one rising edge with the currently driven inputs.
  task automatic model_update();
    bit   acc;
    bit   iss;
    bit   pop;
    cmd_t head;
    acc = cmd_valid && m_ready();
    iss = m_req_valid() && dma_req_ready;
    pop = dma_rsp_valid && (m_cnt > 0);
    if (dma_rsp_valid && m_cnt == 0) m_spur = 1'b1;
    m_cpl_v = pop;
    if (pop) m_cpl_tag = m_tagq.pop_front();
    if (iss) begin
      head = m_cmdq.pop_front();
      m_tagq.push_back(head.t);
    end
    if (acc) begin
      head.d = cmd_descr;
      head.t = cmd_tag;
      m_cmdq.push_back(head);
    end
    m_cnt = m_cnt + (iss ? 1 : 0) - (pop ? 1 : 0);
  endtask

  // Advance one cycle: inputs are already driven, count a DUT handshake,
  // update the model at the rising edge and return at the falling edge.
  task automatic step();
    if (dma_req_valid && dma_req_ready) dut_issues++;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (dma_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", dma_req_valid); end
    checks++; if (cpl_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpl_valid: got %b expected 0", cpl_valid); end
    checks++; if (cpl_tag !== 8'h00) begin errors++; $display("[TB] FAIL reset_cpl_tag: got %h expected 00", cpl_tag); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding); end
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got %b expected 1", idle); end
    checks++; if (spurious !== 1'b0) begin errors++; $display("[TB] FAIL reset_spurious: got %b expected 0", spurious); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    descr_t d;
    d = $urandom;
    cmd_valid = 1'b1; cmd_descr = d; cmd_tag = 8'h11; dma_req_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++; if (dma_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_req_valid: got %b expected 1", dma_req_valid); end
    checks++; if (dma_req !== d) begin errors++; $display("[TB] FAIL single_req_descr: got %h expected %h", dma_req, d); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("[TB] FAIL single_out_before: got %0d expected 0", outstanding); end
    checks++; if (idle !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %b expected 0", idle); end
    step();
    checks++; if (outstanding !== 4'd1) begin errors++; $display("[TB] FAIL single_out_issued: got %0d expected 1", outstanding); end
    checks++; if (dma_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_req_drop: got %b expected 0", dma_req_valid); end
    step();
    step();
    dma_rsp_valid = 1'b1;
    step();
    dma_rsp_valid = 1'b0;
    checks++; if (cpl_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_cpl_valid: got %b expected 1", cpl_valid); end
    checks++; if (cpl_tag !== 8'h11) begin errors++; $display("[TB] FAIL single_cpl_tag: got %h expected 11", cpl_tag); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("[TB] FAIL single_out_done: got %0d expected 0", outstanding); end
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_back: got %b expected 1", idle); end
    step();
    checks++; if (cpl_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_cpl_one_cycle: got %b expected 0", cpl_valid); end
    checks++; if (cpl_tag !== 8'h11) begin errors++; $display("[TB] FAIL single_cpl_tag_hold: got %h expected 11", cpl_tag); end
  endtask

  task automatic test_backpressure();
    descr_t exp_d[5];
    int     next;
    dma_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_d[i]  = $urandom;
      cmd_valid = 1'b1; cmd_descr = exp_d[i]; cmd_tag = 8'h20 + 8'(i);
      checks++; if (cmd_ready !== (i < 4)) begin errors++; $display("[TB] FAIL bp_cmd_ready[%0d]: got %b expected %b", i, cmd_ready, (i < 4)); end
      step();
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (dma_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_req_valid[%0d]: got %b expected 1", k, dma_req_valid); end
      checks++; if (dma_req !== exp_d[0]) begin errors++; $display("[TB] FAIL bp_req_stable[%0d]: got %h expected %h", k, dma_req, exp_d[0]); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full[%0d]: got %b expected 0", k, cmd_ready); end
      step();
    end
    next = 0;
    dma_req_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && next < 4; cyc++) begin
      dma_rsp_valid = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
      step();
      if (cpl_valid === 1'b1) begin
        checks++; if (cpl_tag !== 8'h20 + 8'(next)) begin errors++; $display("[TB] FAIL bp_cpl_order[%0d]: got %h expected %h", next, cpl_tag, 8'h20 + 8'(next)); end
        next++;
      end
    end
    dma_rsp_valid = 1'b0;
    checks++; if (next !== 4) begin errors++; $display("[TB] FAIL bp_cpl_count: got %0d expected 4", next); end
    step();
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL bp_idle: got %b expected 1", idle); end
  endtask

  task automatic test_outstanding_limit();
    int base;
    int pushed;
    int next;
    base   = dut_issues;
    pushed = 0;
    dma_req_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      cmd_valid = (pushed < 10);
      cmd_tag   = 8'(pushed + 1);
      cmd_descr = $urandom;
      if (cmd_valid && m_ready()) pushed++;
      step();
    end
    cmd_valid = 1'b0;
    checks++; if (dut_issues - base !== 8) begin errors++; $display("[TB] FAIL lim_issue_count: got %0d expected 8", dut_issues - base); end
    checks++; if (outstanding !== 4'd8) begin errors++; $display("[TB] FAIL lim_outstanding: got %0d expected 8", outstanding); end
    checks++; if (dma_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL lim_req_stalled: got %b expected 0", dma_req_valid); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL lim_cmd_ready: got %b expected 1", cmd_ready); end
    dma_rsp_valid = 1'b1;
    #1;
    checks++; if (dma_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL lim_no_comb_path: got %b expected 0", dma_req_valid); end
    step();
    dma_rsp_valid = 1'b0;
    checks++; if (cpl_valid !== 1'b1) begin errors++; $display("[TB] FAIL lim_cpl_valid: got %b expected 1", cpl_valid); end
    checks++; if (cpl_tag !== 8'd1) begin errors++; $display("[TB] FAIL lim_cpl_tag: got %h expected 01", cpl_tag); end
    checks++; if (outstanding !== 4'd7) begin errors++; $display("[TB] FAIL lim_out_freed: got %0d expected 7", outstanding); end
    checks++; if (dma_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL lim_req_resume: got %b expected 1", dma_req_valid); end
    step();
    checks++; if (dut_issues - base !== 9) begin errors++; $display("[TB] FAIL lim_ninth_issue: got %0d expected 9", dut_issues - base); end
    checks++; if (outstanding !== 4'd8) begin errors++; $display("[TB] FAIL lim_out_refill: got %0d expected 8", outstanding); end
    next = 2;
    for (int cyc = 0; cyc < 80 && next < 11; cyc++) begin
      dma_rsp_valid = (m_cnt > 0) && ($urandom_range(0, 2) != 0);
      step();
      if (cpl_valid === 1'b1) begin
        checks++; if (cpl_tag !== 8'(next)) begin errors++; $display("[TB] FAIL lim_cpl_order[%0d]: got %h expected %h", next, cpl_tag, 8'(next)); end
        next++;
      end
    end
    dma_rsp_valid = 1'b0;
    checks++; if (next !== 11) begin errors++; $display("[TB] FAIL lim_cpl_count: got %0d expected 11", next); end
  endtask

  task automatic test_simultaneous();
    logic [TagW-1:0] t[4];
    int next;
    step();
    dma_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t[i] = 8'($urandom);
      cmd_valid = 1'b1; cmd_descr = $urandom; cmd_tag = t[i];
      step();
    end
    cmd_valid = 1'b0;
    dma_req_ready = 1'b1;
    step(); step(); step();
    checks++; if (outstanding !== 4'd3) begin errors++; $display("[TB] FAIL sim_out_before: got %0d expected 3", outstanding); end
    dma_rsp_valid = 1'b1;
    step();
    dma_rsp_valid = 1'b0;
    checks++; if (outstanding !== 4'd3) begin errors++; $display("[TB] FAIL sim_out_same: got %0d expected 3", outstanding); end
    checks++; if (cpl_valid !== 1'b1) begin errors++; $display("[TB] FAIL sim_cpl_valid: got %b expected 1", cpl_valid); end
    checks++; if (cpl_tag !== t[0]) begin errors++; $display("[TB] FAIL sim_cpl_oldest: got %h expected %h", cpl_tag, t[0]); end
    next = 1;
    for (int cyc = 0; cyc < 40 && next < 4; cyc++) begin
      dma_rsp_valid = (m_cnt > 0);
      step();
      if (cpl_valid === 1'b1) begin
        checks++; if (cpl_tag !== t[next]) begin errors++; $display("[TB] FAIL sim_cpl_order[%0d]: got %h expected %h", next, cpl_tag, t[next]); end
        next++;
      end
    end
    dma_rsp_valid = 1'b0;
    checks++; if (next !== 4) begin errors++; $display("[TB] FAIL sim_cpl_count: got %0d expected 4", next); end
    step();
  endtask

  task automatic test_spurious();
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL spur_idle_before: got %b expected 1", idle); end
    checks++; if (spurious !== 1'b0) begin errors++; $display("[TB] FAIL spur_clear_before: got %b expected 0", spurious); end
    dma_rsp_valid = 1'b1;
    step();
    dma_rsp_valid = 1'b0;
    checks++; if (spurious !== 1'b1) begin errors++; $display("[TB] FAIL spur_set: got %b expected 1", spurious); end
    checks++; if (cpl_valid !== 1'b0) begin errors++; $display("[TB] FAIL spur_no_cpl: got %b expected 0", cpl_valid); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("[TB] FAIL spur_out: got %0d expected 0", outstanding); end
    step(); step(); step();
    checks++; if (spurious !== 1'b1) begin errors++; $display("[TB] FAIL spur_sticky: got %b expected 1", spurious); end
    checks++; if (cpl_valid !== 1'b0) begin errors++; $display("[TB] FAIL spur_no_cpl_late: got %b expected 0", cpl_valid); end
  endtask

  task automatic test_random();
    int phase;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++; if (cmd_ready !== m_ready()) begin errors++; $display("[TB] FAIL rnd_cmd_ready@%0d: got %b expected %b", cyc, cmd_ready, m_ready()); end
      checks++; if (dma_req_valid !== m_req_valid()) begin errors++; $display("[TB] FAIL rnd_req_valid@%0d: got %b expected %b", cyc, dma_req_valid, m_req_valid()); end
      if (m_req_valid()) begin
        checks++; if (dma_req !== m_cmdq[0].d) begin errors++; $display("[TB] FAIL rnd_req_descr@%0d: got %h expected %h", cyc, dma_req, m_cmdq[0].d); end
      end
      checks++; if (cpl_valid !== m_cpl_v) begin errors++; $display("[TB] FAIL rnd_cpl_valid@%0d: got %b expected %b", cyc, cpl_valid, m_cpl_v); end
      checks++; if (cpl_tag !== m_cpl_tag) begin errors++; $display("[TB] FAIL rnd_cpl_tag@%0d: got %h expected %h", cyc, cpl_tag, m_cpl_tag); end
      checks++; if (outstanding !== 4'(m_cnt)) begin errors++; $display("[TB] FAIL rnd_outstanding@%0d: got %0d expected %0d", cyc, outstanding, m_cnt); end
      checks++; if (idle !== m_idle()) begin errors++; $display("[TB] FAIL rnd_idle@%0d: got %b expected %b", cyc, idle, m_idle()); end
      checks++; if (spurious !== m_spur) begin errors++; $display("[TB] FAIL rnd_spurious@%0d: got %b expected %b", cyc, spurious, m_spur); end
      phase     = cyc / 100;
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_descr = $urandom;
      cmd_tag   = 8'($urandom);
      case (phase)
        0: begin dma_req_ready = ($urandom_range(0, 1) == 1); dma_rsp_valid = ($urandom_range(0, 1) == 1); end
        1: begin dma_req_ready = 1'b1; dma_rsp_valid = ($urandom_range(0, 7) == 0); end
        2: begin dma_req_ready = ($urandom_range(0, 4) == 0); dma_rsp_valid = ($urandom_range(0, 1) == 1); end
        default: begin dma_req_ready = ($urandom_range(0, 3) != 0); dma_rsp_valid = ($urandom_range(0, 3) != 0); end
      endcase
      step();
    end
    cmd_valid = 1'b0;
    dma_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    dma_req_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && !m_idle(); cyc++) begin
      dma_rsp_valid = (m_cnt > 0);
      step();
    end
    dma_rsp_valid = 1'b0;
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL mid_drain_idle: got %b expected 1", idle); end
    dma_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_descr = $urandom; cmd_tag = 8'h40 + 8'(i);
      step();
    end
    cmd_valid = 1'b0;
    dma_req_ready = 1'b1;
    step(); step();
    dma_req_ready = 1'b0;
    cmd_valid = 1'b1; cmd_descr = $urandom; cmd_tag = 8'h44;
    step();
    cmd_valid = 1'b0;
    checks++; if (outstanding !== 4'd2) begin errors++; $display("[TB] FAIL mid_out_setup: got %0d expected 2", outstanding); end
    checks++; if (dma_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_req_setup: got %b expected 1", dma_req_valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (dma_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_req_valid: got %b expected 0", dma_req_valid); end
    checks++; if (cpl_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_cpl_valid: got %b expected 0", cpl_valid); end
    checks++; if (cpl_tag !== 8'h00) begin errors++; $display("[TB] FAIL mid_cpl_tag: got %h expected 00", cpl_tag); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("[TB] FAIL mid_outstanding: got %0d expected 0", outstanding); end
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL mid_idle: got %b expected 1", idle); end
    checks++; if (spurious !== 1'b0) begin errors++; $display("[TB] FAIL mid_spurious: got %b expected 0", spurious); end
    @(negedge clk);
    rst_n = 1'b1;
    dma_req_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      dma_rsp_valid = (cyc == 1);
      step();
      checks++; if (cpl_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_cpl[%0d]: got %b expected 0", cyc, cpl_valid); end
      checks++; if (dma_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_req[%0d]: got %b expected 0", cyc, dma_req_valid); end
      checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL mid_idle_after[%0d]: got %b expected 1", cyc, idle); end
    end
    dma_rsp_valid = 1'b0;
    checks++; if (spurious !== 1'b1) begin errors++; $display("[TB] FAIL mid_stale_rsp_spurious: got %b expected 1", spurious); end
  endtask

  initial begin
    rst_n         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_descr     = '0;
    cmd_tag       = '0;
    dma_req_ready = 1'b0;
    dma_rsp_valid = 1'b0;
    $display("[TB] dma_cmd_issuer bench start");
    test_reset();
    test_single();
    test_backpressure();
    test_outstanding_limit();
    test_simultaneous();
    test_spurious();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
